// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of one of four pins in prescaled ticks.
// States: IDLE counters cleared | ARM wait for first rise | HIGH timing high phase | LOW timing low phase
module pwm_capture #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_channel,
  input  logic [31:0]      i_prescalor,
  input  logic [3:0]       i_pwm_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic [1:0]       r_state;
  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_chan_q;
  logic [31:0]      r_cnt_pres;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_hi_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_overflow;

  logic             w_pin;
  logic             w_rise;
  logic             w_fall;
  logic             w_tick;
  logic             w_pres_wrap;
  logic             w_chan_chg;
  logic             w_sat;
  logic [CNT_W-1:0] w_tick_ext;
  logic [CNT_W-1:0] w_meas;

  assign w_pin       = i_pwm_in[i_channel];
  assign w_rise      = r_s2 & ~r_s3;
  assign w_fall      = ~r_s2 & r_s3;
  assign w_tick      = (r_cnt_pres == i_prescalor);
  // A lowered prescalor below the current count wraps without producing a tick.
  assign w_pres_wrap = (r_cnt_pres >= i_prescalor);
  assign w_chan_chg  = (i_channel != r_chan_q);
  assign w_tick_ext  = {{(CNT_W-1){1'b0}}, w_tick};
  assign w_meas      = r_count + w_tick_ext;
  assign w_sat       = (&r_count) & w_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_chan_q <= 2'd0;
    end else begin
      r_chan_q <= i_channel;
      // Reload the whole chain on a channel switch so the old pin's level cannot look like an edge.
      if (i_enable && w_chan_chg) begin
        r_s1 <= w_pin;
        r_s2 <= w_pin;
        r_s3 <= w_pin;
      end else begin
        r_s1 <= w_pin;
        r_s2 <= r_s1;
        r_s3 <= r_s2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt_pres  <= 32'd0;
      r_count     <= '0;
      r_hi_lat    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_enable) begin
        r_state    <= S_IDLE;
        r_cnt_pres <= 32'd0;
        r_count    <= '0;
        r_hi_lat   <= '0;
        r_overflow <= 1'b0;
      end else if (w_chan_chg) begin
        r_state    <= S_ARM;
        r_cnt_pres <= 32'd0;
        r_count    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_ARM;
            r_cnt_pres <= 32'd0;
            r_count    <= '0;
          end
          S_ARM: begin
            r_cnt_pres <= 32'd0;
            r_count    <= '0;
            if (w_rise) r_state <= S_HIGH;
          end
          S_HIGH, S_LOW: begin
            if (w_sat) begin
              r_overflow <= 1'b1;
              r_state    <= S_ARM;
              r_cnt_pres <= 32'd0;
              r_count    <= '0;
            end else if (r_state == S_HIGH && w_fall) begin
              r_hi_lat   <= w_meas;
              r_count    <= w_meas;
              r_cnt_pres <= w_pres_wrap ? 32'd0 : r_cnt_pres + 32'd1;
              r_state    <= S_LOW;
            end else if (r_state == S_LOW && w_rise) begin
              r_period    <= w_meas;
              r_high_time <= r_hi_lat;
              r_valid     <= 1'b1;
              r_overflow  <= 1'b0;
              r_count     <= '0;
              r_cnt_pres  <= 32'd0;
              r_state     <= S_HIGH;
            end else begin
              r_count    <= w_meas;
              r_cnt_pres <= w_pres_wrap ? 32'd0 : r_cnt_pres + 32'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high_time;
  assign o_valid     = r_valid;
  assign o_overflow  = r_overflow;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-capture block for the PWM subsystem: it measures the period and high time of an external PWM waveform on one of four selectable input pins. Timing is in prescaled ticks, using the same prescaler convention as the PWM generator, so a waveform the generator produces with prescalor P and max_count M reads back as period M+1. Results are published with a one-cycle valid strobe for the bus/interrupt logic.

## Interface
- CNT_W, 32, width of the measurement counter and of the period/high_time outputs (2..32)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = capture running; 0 = idle
- channel  input  2  selects pwm_in[channel] as the measured source
- prescalor  input  32  a tick occurs every prescalor+1 clk cycles
- pwm_in  input  4  asynchronous PWM inputs
- period  output  CNT_W  ticks between the last two rising edges
- high_time  output  CNT_W  ticks between the last rising edge and the following falling edge
- valid  output  1  one-cycle pulse when period/high_time update
- overflow  output  1  sticky flag: the counter saturated and the measurement was discarded

## Operation
- Input path: pwm_in[channel] → 2-FF synchronizer (s1, s2) → delay register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Prescaler: cnt_pres counts 0..prescalor. tick = (cnt_pres == prescalor), then cnt_pres wraps to 0. With prescalor=0, tick=1 every cycle.
- Measurement counter `count`, CNT_W bits:
  - increments on tick;
  - measured value at an edge = count + tick (the tick in the edge cycle counts).
- States:
  - IDLE: counters held at 0. Goes to ARM when enable=1.
  - ARM: waits for rise; a high level at arm time is ignored. On rise: count←0, cnt_pres←0, go to HIGH.
  - HIGH: on fall: hi_lat←count+tick, go to LOW.
  - LOW: on rise: period←count+tick, high_time←hi_lat, valid←1, overflow←0, count←0, cnt_pres←0, go to HIGH.
- The first rise after ARM never produces valid. The first valid comes on the second rise.
- Saturation: in HIGH or LOW, if count = 2^CNT_W−1 and tick=1, then overflow←1 and the state goes to ARM. Outputs keep their previous values.
- enable=0 in any state: go to IDLE next cycle; count, cnt_pres, hi_lat ← 0; overflow←0. period and high_time are held.
- channel changes while enabled (compared against a registered copy): go to ARM; count and cnt_pres ← 0; s1..s3 are reloaded from the new pin. Edges detected in that same cycle are ignored.
- Priority when events coincide: reset > enable=0 > channel change > saturation > edge.
- prescalor changes take effect at the next cnt_pres comparison. If cnt_pres > prescalor, cnt_pres wraps to 0 with no tick.

## Timing
- Reset values: period=0, high_time=0, valid=0, overflow=0, state IDLE, all counters 0, s1..s3=0.
- Pin edge to rise/fall detection: 2 cycles (edge sampled at cycle k, detected at k+2).
- rise detection to valid pulse: valid is high in the cycle after detection, for exactly 1 cycle. period/high_time are stable from that cycle until the next update.
- With prescalor=0, for an input with period Tp and high time Th in clk cycles: period=Tp, high_time=Th (exact when edges are clk-aligned).
- Pulses shorter than 1 clk may be missed. At most one valid per input period.
- Reset mid-measurement: all outputs return to reset values on the next cycle. No valid is produced for the partial measurement.

## Test plan
- prescalor=0, channel=0, a 100-cycle period with 30 high, 3 periods → two valid pulses (on 2nd and 3rd rise), each with period=100, high_time=30. No valid on the 1st rise.
- prescalor=4, channel=2, 100-cycle period with 25 high, aligned to the tick phase → period=20, high_time=5. Activity on other pins is ignored.
- CNT_W=8, prescalor=0, input held high for 300 cycles after a rise → overflow=1 at count 255, state ARM, no valid, previous results held. The next two full periods → valid with overflow cleared to 0.
- enable dropped to 0 in mid-HIGH → IDLE, no valid, period/high_time retain the last values. Re-enabling requires two rises before the next valid.
- Switch channel 0→1 in mid-LOW while pin1 rises in the same cycle → that rise is ignored, state ARM. Valid comes only after the 2nd subsequent rise on pin1.
- Reset asserted 1 cycle before an expected valid → valid stays 0, and period, high_time and overflow are all 0 on the next cycle.
